weighted_round_robin: RTL and testbench
=======================================

Name: weighted_round_robin

Overview:
Parametrised successor to the queue round-robin arbiter. Selects which of QUEUE_QUANTITY input queues is popped each cycle. Supports plain round-robin and weighted (per-queue credit) modes, plus downstream backpressure. Sits between the queue bank and the shared output path, driving each queue's pop through selector/out_enb.

Parameters:
QUEUE_QUANTITY, 4, number of queues arbitrated (>=2)
DATA_BITS, 8, data width of the arbitrated path; passed through for instantiation compatibility, no internal use
WEIGHT_BITS, 4, width of each per-queue weight and of the credit counter

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
enb  input  1  arbiter enable; when 0 all state holds and out_enb=0
buf_empty  input  QUEUE_QUANTITY  bit i = 1 when queue i is empty
dst_full  input  1  downstream cannot accept; blocks pops
mode  input  1  0 = plain round-robin (1 pop per turn), 1 = weighted
weights  input  QUEUE_QUANTITY*WEIGHT_BITS  weight of queue i at bits [i*WEIGHT_BITS +: WEIGHT_BITS]
selector  output  $clog2(QUEUE_QUANTITY)  index of queue currently granted (registered)
out_enb  output  1  pop strobe for queue selector this cycle (combinational qualify of registered grant)
credit_left  output  WEIGHT_BITS  remaining pops in current turn (registered, debug/verification)

Behaviour:
- Reset (rst=1 at posedge): selector=0, grant_valid=0, credit_left=0, search pointer ptr=0. Hence out_enb=0. rst has priority over enb.
- out_enb = grant_valid & enb & ~dst_full & ~buf_empty[selector]. Pop occurs in every cycle out_enb=1.
- Effective weight W_i = 1 if mode=0; else weights[i], with weight 0 treated as 1. W is sampled when a queue is granted; later changes to weights/mode take effect at the next grant.
- States: IDLE (grant_valid=0), SERVE (grant_valid=1). At each posedge with rst=0 and enb=1:
  - IDLE: circular search from ptr for the lowest-distance i with buf_empty[i]=0. If found: selector<=i, credit_left<=W_i, SERVE. If none: stay IDLE.
  - SERVE, dst_full=1: hold everything, including when buf_empty[selector]=1.
  - SERVE, out_enb=1, credit_left>1: credit_left decrements, selector holds.
  - SERVE, rotate when either (out_enb=1 and credit_left=1) or buf_empty[selector]=1: circular search from selector+1, wrapping to selector itself last.
    - Found j: selector<=j, credit_left<=W_j, stay SERVE.
    - None found: IDLE, ptr<=selector+1 mod QUEUE_QUANTITY, credit_left<=0.
- enb=0: selector, credit_left, grant_valid and ptr hold; out_enb=0.
- Latency: a queue going non-empty while in IDLE gives out_enb=1 on the cycle after the edge that grants it.
- Back-to-back switch on credit exhaustion has no bubble. A granted queue found empty costs one idle cycle before rotation.
- A sole non-empty queue is re-granted to itself with a fresh credit of W. Continuous pops follow. If it empties mid-grant, out_enb drops combinationally that cycle.
- Index arithmetic is modulo QUEUE_QUANTITY, including non-power-of-2 values. Wrap from QUEUE_QUANTITY-1 goes to 0.
- Fairness: with all queues non-empty and dst_full=0, each queue receives exactly W_i consecutive pops per round, in index order.
- Reset mid-turn discards remaining credit; the next grant starts search at 0.

Test Plan:
1. Q=4, mode=0, buf_empty=0000, dst_full=0 → after reset, selector sequence 0,1,2,3,0…, out_enb=1 every cycle from the 2nd cycle after rst drops.
2. mode=1, weights={4,3,2,1} (q3..q0), all non-empty → selector pattern 0,1,1,2,2,2,3,3,3,3 repeating; credit_left counts down W..1 within each turn.
3. mode=1, only q2 non-empty, W2=3 → selector stays 2, out_enb continuous. Set buf_empty[2]=1 → out_enb=0 same cycle, IDLE next, ptr=3.
4. During turn of q1 with credit_left=2, assert dst_full 3 cycles → out_enb=0, selector=1, credit_left=2 held. Release → two more pops of q1, then rotate.
5. Weight 0 in mode 1 on q0, enb toggled low mid-turn → q0 gets exactly 1 pop per round; enb=0 freezes selector/credit_left with out_enb=0.
6. Q=3 (non-power-of-2), rst asserted mid-turn at selector=2 → next cycle selector=0, out_enb=0, credit_left=0; arbitration restarts at q0, wrap 2→0 verified.

Source files
------------

// File: rtl/weighted_round_robin.sv
// rtl/weighted_round_robin.sv - weighted round-robin pop arbiter for a bank of queues
module weighted_round_robin #(
    parameter int QUEUE_QUANTITY = 4,
    parameter int DATA_BITS      = 8,
    parameter int WEIGHT_BITS    = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  enb,
    input  logic [QUEUE_QUANTITY-1:0]             buf_empty,
    input  logic                                  dst_full,
    input  logic                                  mode,
    input  logic [QUEUE_QUANTITY*WEIGHT_BITS-1:0] weights,
    output logic [$clog2(QUEUE_QUANTITY)-1:0]     selector,
    output logic                                  out_enb,
    output logic [WEIGHT_BITS-1:0]                credit_left
);

    // DATA_BITS only guards the width derivation; the data path lives outside this block.
    localparam int SEL_BITS = (QUEUE_QUANTITY > 1 && DATA_BITS > 0) ? $clog2(QUEUE_QUANTITY) : 1;

    typedef enum logic {
        IDLE,
        SERVE
    } state_t;

    state_t                 state_q, state_d;
    logic [SEL_BITS-1:0]    sel_q, sel_d;
    logic [SEL_BITS-1:0]    ptr_q, ptr_d;
    logic [WEIGHT_BITS-1:0] cred_q, cred_d;
    logic [SEL_BITS-1:0]    scan;
    logic [SEL_BITS-1:0]    found_idx;
    logic                   found;
    logic [WEIGHT_BITS-1:0] raw_weight;
    logic [WEIGHT_BITS-1:0] found_weight;

    function automatic logic [SEL_BITS-1:0] wrap_inc(input logic [SEL_BITS-1:0] i);
        return (int'(i) == QUEUE_QUANTITY - 1) ? '0 : i + SEL_BITS'(1);
    endfunction

    // Circular search: from ptr when idle, from selector+1 (selector itself last) when serving.
    always_comb begin
        found     = 1'b0;
        found_idx = '0;
        scan      = (state_q == SERVE) ? wrap_inc(sel_q) : ptr_q;
        for (int k = 0; k < QUEUE_QUANTITY; k++) begin
            if (!found && !buf_empty[scan]) begin
                found     = 1'b1;
                found_idx = scan;
            end
            scan = wrap_inc(scan);
        end
    end

    always_comb begin
        raw_weight   = weights[int'(found_idx)*WEIGHT_BITS +: WEIGHT_BITS];
        found_weight = (!mode || raw_weight == '0) ? WEIGHT_BITS'(1) : raw_weight;
    end

    assign out_enb     = (state_q == SERVE) & enb & ~dst_full & ~buf_empty[sel_q];
    assign selector    = sel_q;
    assign credit_left = cred_q;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cred_d  = cred_q;
        ptr_d   = ptr_q;
        if (enb) begin
            case (state_q)
                IDLE: begin
                    if (found) begin
                        sel_d   = found_idx;
                        cred_d  = found_weight;
                        state_d = SERVE;
                    end
                end
                SERVE: begin
                    if (!dst_full) begin
                        // Rotate on last credit or on a granted queue that has run dry.
                        if (buf_empty[sel_q] || cred_q == WEIGHT_BITS'(1)) begin
                            if (found) begin
                                sel_d  = found_idx;
                                cred_d = found_weight;
                            end else begin
                                state_d = IDLE;
                                ptr_d   = wrap_inc(sel_q);
                                cred_d  = '0;
                            end
                        end else begin
                            cred_d = cred_q - WEIGHT_BITS'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            cred_q  <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cred_q  <= cred_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule

// File: tb/tb_weighted_round_robin.sv
// tb/tb_weighted_round_robin.sv - self-checking bench for weighted_round_robin (Q=4 and Q=3)
module tb_weighted_round_robin;

    logic        clk = 1'b0;
    logic        rst, rst_b, enb, dst_full, mode;
    logic [3:0]  be;
    logic [15:0] weights;
    logic [1:0]  sel_a, sel_b;
    logic        oe_a, oe_b;
    logic [3:0]  cred_a, cred_b;

    int vectors = 0;
    int miscompares = 0;

    // Reference state per arbiter: index 0 = four-queue instance, 1 = three-queue instance.
    int m_sel[2];
    int m_cred[2];
    int m_valid[2];
    int m_ptr[2];

    always #5 clk = ~clk;

    weighted_round_robin #(.QUEUE_QUANTITY(4), .DATA_BITS(8), .WEIGHT_BITS(4)) dut_a (
        .clk(clk), .rst(rst), .enb(enb), .buf_empty(be), .dst_full(dst_full), .mode(mode),
        .weights(weights), .selector(sel_a), .out_enb(oe_a), .credit_left(cred_a)
    );

    weighted_round_robin #(.QUEUE_QUANTITY(3), .DATA_BITS(8), .WEIGHT_BITS(4)) dut_b (
        .clk(clk), .rst(rst_b), .enb(enb), .buf_empty(be[2:0]), .dst_full(dst_full), .mode(mode),
        .weights(weights[11:0]), .selector(sel_b), .out_enb(oe_b), .credit_left(cred_b)
    );

    function automatic int eff_w(input int i);
        int raw;
        raw = int'(weights[i*4 +: 4]);
        if (!mode || raw == 0) return 1;
        return raw;
    endfunction

    function automatic int first_ne(input int q, input int start);
        for (int d = 0; d < q; d++) begin
            if (!be[(start + d) % q]) return (start + d) % q;
        end
        return -1;
    endfunction

    task automatic mdl_step(input int k, input int q, input logic r);
        int j;
        if (r) begin
            m_sel[k] = 0; m_cred[k] = 0; m_valid[k] = 0; m_ptr[k] = 0;
            return;
        end
        if (!enb) return;
        if (m_valid[k] == 0) begin
            j = first_ne(q, m_ptr[k]);
            if (j >= 0) begin
                m_sel[k] = j; m_cred[k] = eff_w(j); m_valid[k] = 1;
            end
        end else if (!dst_full) begin
            if (!be[m_sel[k]] && m_cred[k] > 1) begin
                m_cred[k] = m_cred[k] - 1;
            end else begin
                j = first_ne(q, m_sel[k] + 1);
                if (j >= 0) begin
                    m_sel[k] = j; m_cred[k] = eff_w(j);
                end else begin
                    m_valid[k] = 0; m_ptr[k] = (m_sel[k] + 1) % q; m_cred[k] = 0;
                end
            end
        end
    endtask

    function automatic logic exp_oe(input int k);
        return (m_valid[k] != 0) && enb && !dst_full && !be[m_sel[k]];
    endfunction

    task automatic step();
        @(posedge clk);
        mdl_step(0, 4, rst);
        mdl_step(1, 3, rst_b);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; rst_b = 1'b1; enb = 1'b0; be = 4'hF; dst_full = 1'b0; mode = 1'b0; weights = '0;
        step(); step(); #1;
        vectors++; if (sel_a !== 2'd0) begin miscompares++; $display("FAIL reset_sel got %0d exp 0", sel_a); end
        vectors++; if (oe_a !== 1'b0) begin miscompares++; $display("FAIL reset_oe got %b exp 0", oe_a); end
        vectors++; if (cred_a !== 4'd0) begin miscompares++; $display("FAIL reset_cred got %0d exp 0", cred_a); end
        vectors++; if (sel_b !== 2'd0 || cred_b !== 4'd0) begin
            miscompares++; $display("FAIL reset_b got sel %0d cred %0d exp 0 0", sel_b, cred_b);
        end
    endtask

    task automatic test_plain_rr();
        rst = 1'b0; be = 4'h0; mode = 1'b0; enb = 1'b1; dst_full = 1'b0; #1;
        vectors++; if (oe_a !== 1'b0) begin miscompares++; $display("FAIL rr_first_cycle_oe got %b exp 0", oe_a); end
        for (int k = 0; k < 12; k++) begin
            step(); #1;
            vectors++; if (sel_a !== 2'(k % 4)) begin miscompares++; $display("FAIL rr_sel k=%0d got %0d exp %0d", k, sel_a, k % 4); end
            vectors++; if (oe_a !== 1'b1) begin miscompares++; $display("FAIL rr_oe k=%0d got %b exp 1", k, oe_a); end
            vectors++; if (cred_a !== 4'd1) begin miscompares++; $display("FAIL rr_cred k=%0d got %0d exp 1", k, cred_a); end
        end
    endtask

    task automatic test_weighted();
        int ps[$];
        int pc[$];
        rst = 1'b1; step();
        rst = 1'b0; mode = 1'b1; weights = 16'h4321; be = 4'h0;
        for (int i = 0; i < 4; i++) begin
            for (int c = int'(weights[i*4 +: 4]); c >= 1; c--) begin ps.push_back(i); pc.push_back(c); end
        end
        step();
        for (int k = 0; k < 20; k++) begin
            #1;
            vectors++; if (sel_a !== 2'(ps[k % ps.size()])) begin
                miscompares++; $display("FAIL wrr_sel k=%0d got %0d exp %0d", k, sel_a, ps[k % ps.size()]);
            end
            vectors++; if (cred_a !== 4'(pc[k % pc.size()])) begin
                miscompares++; $display("FAIL wrr_cred k=%0d got %0d exp %0d", k, cred_a, pc[k % pc.size()]);
            end
            vectors++; if (oe_a !== 1'b1) begin miscompares++; $display("FAIL wrr_oe k=%0d got %b exp 1", k, oe_a); end
            step();
        end
    endtask

    task automatic test_sole_queue();
        rst = 1'b1; step();
        rst = 1'b0; mode = 1'b1; weights = 16'h0300; be = 4'b1011;
        step();
        for (int k = 0; k < 7; k++) begin
            #1;
            vectors++; if (sel_a !== 2'd2 || oe_a !== 1'b1) begin
                miscompares++; $display("FAIL sole_grant k=%0d got sel %0d oe %b exp 2 1", k, sel_a, oe_a);
            end
            vectors++; if (cred_a !== 4'(3 - k % 3)) begin
                miscompares++; $display("FAIL sole_cred k=%0d got %0d exp %0d", k, cred_a, 3 - k % 3);
            end
            step();
        end
        be = 4'b1111; #1;
        vectors++; if (oe_a !== 1'b0) begin miscompares++; $display("FAIL sole_empty_oe got %b exp 0", oe_a); end
        step(); #1;
        vectors++; if (oe_a !== 1'b0 || cred_a !== 4'd0) begin
            miscompares++; $display("FAIL sole_idle got oe %b cred %0d exp 0 0", oe_a, cred_a);
        end
        be = 4'b0110;
        step(); #1;
        vectors++; if (sel_a !== 2'd3 || cred_a !== 4'd1 || oe_a !== 1'b1) begin
            miscompares++; $display("FAIL sole_ptr_resume got sel %0d cred %0d oe %b exp 3 1 1", sel_a, cred_a, oe_a);
        end
    endtask

    task automatic test_backpressure();
        rst = 1'b1; step();
        rst = 1'b0; mode = 1'b1; weights = 16'h1131; be = 4'h0;
        step(); step(); step(); #1;
        vectors++; if (sel_a !== 2'd1 || cred_a !== 4'd2) begin
            miscompares++; $display("FAIL bp_setup got sel %0d cred %0d exp 1 2", sel_a, cred_a);
        end
        dst_full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            vectors++; if (oe_a !== 1'b0 || sel_a !== 2'd1 || cred_a !== 4'd2) begin
                miscompares++; $display("FAIL bp_hold k=%0d got oe %b sel %0d cred %0d exp 0 1 2", k, oe_a, sel_a, cred_a);
            end
            step();
        end
        dst_full = 1'b0; #1;
        vectors++; if (oe_a !== 1'b1 || sel_a !== 2'd1 || cred_a !== 4'd2) begin
            miscompares++; $display("FAIL bp_release got oe %b sel %0d cred %0d exp 1 1 2", oe_a, sel_a, cred_a);
        end
        step(); #1;
        vectors++; if (oe_a !== 1'b1 || sel_a !== 2'd1 || cred_a !== 4'd1) begin
            miscompares++; $display("FAIL bp_last got oe %b sel %0d cred %0d exp 1 1 1", oe_a, sel_a, cred_a);
        end
        step(); #1;
        vectors++; if (sel_a !== 2'd2 || cred_a !== 4'd1) begin
            miscompares++; $display("FAIL bp_rotate got sel %0d cred %0d exp 2 1", sel_a, cred_a);
        end
    endtask

    task automatic test_zero_weight_enb();
        int ps[$];
        int pc[$];
        int pos;
        int w;
        rst = 1'b1; step();
        rst = 1'b0; mode = 1'b1; weights = 16'h1210; be = 4'h0; enb = 1'b1;
        for (int i = 0; i < 4; i++) begin
            w = int'(weights[i*4 +: 4]);
            if (w == 0) w = 1;
            for (int c = w; c >= 1; c--) begin ps.push_back(i); pc.push_back(c); end
        end
        step();
        pos = 0;
        for (int k = 0; k < 30; k++) begin
            enb = !(k % 7 == 3 || k % 7 == 4);
            #1;
            vectors++; if (sel_a !== 2'(ps[pos % ps.size()]) || cred_a !== 4'(pc[pos % pc.size()])) begin
                miscompares++;
                $display("FAIL zw_state k=%0d got sel %0d cred %0d exp %0d %0d", k, sel_a, cred_a, ps[pos % ps.size()], pc[pos % pc.size()]);
            end
            vectors++; if (oe_a !== enb) begin miscompares++; $display("FAIL zw_oe k=%0d got %b exp %b", k, oe_a, enb); end
            if (enb) pos++;
            step();
        end
        enb = 1'b1;
    endtask

    task automatic test_q3_reset();
        int es[7] = '{0, 1, 2, 2, 0, 1, 2};
        int ec[7] = '{1, 1, 2, 1, 1, 1, 2};
        mode = 1'b1; weights = 16'h0211; be = 4'h0; dst_full = 1'b0; enb = 1'b1; rst_b = 1'b0;
        step();
        for (int k = 0; k < 7; k++) begin
            #1;
            vectors++; if (sel_b !== 2'(es[k]) || cred_b !== 4'(ec[k]) || oe_b !== 1'b1) begin
                miscompares++;
                $display("FAIL q3_seq k=%0d got sel %0d cred %0d oe %b exp %0d %0d 1", k, sel_b, cred_b, oe_b, es[k], ec[k]);
            end
            if (k < 6) step();
        end
        rst_b = 1'b1;
        step(); #1;
        vectors++; if (sel_b !== 2'd0 || oe_b !== 1'b0 || cred_b !== 4'd0) begin
            miscompares++; $display("FAIL q3_reset got sel %0d oe %b cred %0d exp 0 0 0", sel_b, oe_b, cred_b);
        end
        rst_b = 1'b0;
        step(); #1;
        vectors++; if (sel_b !== 2'd0 || cred_b !== 4'd1 || oe_b !== 1'b1) begin
            miscompares++; $display("FAIL q3_restart got sel %0d cred %0d oe %b exp 0 1 1", sel_b, cred_b, oe_b);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            be       = 4'($urandom) & 4'($urandom);
            dst_full = ($urandom_range(0, 3) == 0);
            enb      = ($urandom_range(0, 7) != 0);
            rst      = ($urandom_range(0, 49) == 0);
            rst_b    = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            if ($urandom_range(0, 7) == 0) weights = 16'($urandom);
            #1;
            vectors++; if (sel_a !== 2'(m_sel[0]) || cred_a !== 4'(m_cred[0])) begin
                miscompares++; $display("FAIL rnd_a_state k=%0d got %0d/%0d exp %0d/%0d", k, sel_a, cred_a, m_sel[0], m_cred[0]);
            end
            vectors++; if (oe_a !== exp_oe(0)) begin
                miscompares++; $display("FAIL rnd_a_oe k=%0d got %b exp %b", k, oe_a, exp_oe(0));
            end
            vectors++; if (sel_b !== 2'(m_sel[1]) || cred_b !== 4'(m_cred[1])) begin
                miscompares++; $display("FAIL rnd_b_state k=%0d got %0d/%0d exp %0d/%0d", k, sel_b, cred_b, m_sel[1], m_cred[1]);
            end
            vectors++; if (oe_b !== exp_oe(1)) begin
                miscompares++; $display("FAIL rnd_b_oe k=%0d got %b exp %b", k, oe_b, exp_oe(1));
            end
            step();
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_sel[k] = 0; m_cred[k] = 0; m_valid[k] = 0; m_ptr[k] = 0;
        end
        test_reset();
        test_plain_rr();
        test_weighted();
        test_sole_queue();
        test_backpressure();
        test_zero_weight_enb();
        test_q3_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
